i2c_sequencer: RTL

I2C_SEQUENCER -- requirements
Module: i2c_sequencer

---
 rtl/i2c_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_sequencer.sv
// I2C register-access sequencer: expands one write/read request into START/WRITE/READ/STOP
// primitive ops, each run through a 4-phase enable/complete handshake guarded by a timeout.
module i2c_sequencer #(
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rw,
   input  logic [6:0]  devAddr,
   input  logic [7:0]  regAddr,
   input  logic [1:0]  numBytes,
   input  logic [31:0] wrData,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [31:0] rdData,
   output logic [1:0]  i2cInstruction,
   output logic        i2cEnable,
   output logic [7:0]  i2cByteToSend,
   input  logic [7:0]  i2cByteReceived,
   input  logic        i2cComplete,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_LOW  = 3'd2,
      WAIT_HIGH = 3'd3,
      RELEASE   = 3'd4,
      FINISH    = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      ST_START, ST_DEVW, ST_REG, ST_WDATA, ST_RSTART, ST_DEVR, ST_READ, ST_STOP
   } step_t;

   localparam logic [1:0]  OP_START = 2'b00;
   localparam logic [1:0]  OP_STOP  = 2'b01;
   localparam logic [1:0]  OP_READ  = 2'b10;
   localparam logic [1:0]  OP_WRITE = 2'b11;
   localparam logic [11:0] TO_LAST  = 12'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   step_t       step, step_nxt;
   logic [1:0]  byte_cnt, cnt_nxt, num_q, wr_idx;
   logic [11:0] tcnt;
   logic        rw_q, to_flag, load_op, to_hit;
   logic [6:0]  dev_q;
   logic [7:0]  reg_q, op_byte, wr_byte;
   logic [1:0]  op_instr;
   logic [31:0] wr_q;

   // Handshake: enable rises in ISSUE with instruction/byte already stable; the primitive
   // drops complete to accept, raises it when finished, and enable then falls for one cycle.
   assign busy      = (state != IDLE);
   assign done      = (state == FINISH);
   assign timeout   = done && to_flag;
   assign i2cEnable = (state == ISSUE) || (state == WAIT_LOW) || (state == WAIT_HIGH);
   assign fsm_state = state;

   assign to_hit = (tcnt == TO_LAST) &&
                   (((state == WAIT_LOW) && i2cComplete) || ((state == WAIT_HIGH) && !i2cComplete));

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      cnt_nxt   = byte_cnt;
      load_op   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ISSUE;
               step_nxt  = ST_START;
               cnt_nxt   = 2'd0;
               load_op   = 1'b1;
            end
         end
         ISSUE:     state_nxt = WAIT_LOW;
         WAIT_LOW: begin
            if (!i2cComplete) state_nxt = WAIT_HIGH;
            else if (to_hit)  state_nxt = FINISH;
         end
         WAIT_HIGH: begin
            if (i2cComplete) state_nxt = RELEASE;
            else if (to_hit) state_nxt = FINISH;
         end
         RELEASE: begin
            state_nxt = ISSUE;
            load_op   = 1'b1;
            case (step)
               ST_START:  step_nxt = ST_DEVW;
               ST_DEVW:   step_nxt = ST_REG;
               ST_REG:    step_nxt = rw_q ? ST_RSTART : ST_WDATA;
               ST_RSTART: step_nxt = ST_DEVR;
               ST_DEVR:   step_nxt = ST_READ;
               ST_WDATA, ST_READ: begin
                  if (byte_cnt == num_q) begin
                     step_nxt = ST_STOP;
                  end else begin
                     cnt_nxt = byte_cnt + 2'd1;
                  end
               end
               ST_STOP: begin
                  state_nxt = FINISH;
                  load_op   = 1'b0;
               end
               default: step_nxt = ST_STOP;
            endcase
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Most-significant used byte goes out first.
   assign wr_idx  = num_q - cnt_nxt;
   assign wr_byte = wr_q[{wr_idx, 3'b000} +: 8];

   always_comb begin
      op_instr = OP_START;
      op_byte  = 8'h00;
      case (step_nxt)
         ST_START, ST_RSTART: op_instr = OP_START;
         ST_STOP:             op_instr = OP_STOP;
         ST_READ:             op_instr = OP_READ;
         ST_DEVW: begin
            op_instr = OP_WRITE;
            op_byte  = {dev_q, 1'b0};
         end
         ST_DEVR: begin
            op_instr = OP_WRITE;
            op_byte  = {dev_q, 1'b1};
         end
         ST_REG: begin
            op_instr = OP_WRITE;
            op_byte  = reg_q;
         end
         ST_WDATA: begin
            op_instr = OP_WRITE;
            op_byte  = wr_byte;
         end
         default: op_instr = OP_START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         step           <= ST_START;
         byte_cnt       <= 2'd0;
         tcnt           <= 12'd0;
         rw_q           <= 1'b0;
         dev_q          <= 7'd0;
         reg_q          <= 8'd0;
         num_q          <= 2'd0;
         wr_q           <= 32'd0;
         to_flag        <= 1'b0;
         i2cInstruction <= OP_START;
         i2cByteToSend  <= 8'd0;
         rdData         <= 32'd0;
      end else begin
         state    <= state_nxt;
         step     <= step_nxt;
         byte_cnt <= cnt_nxt;
         if ((state == IDLE) && start) begin
            rw_q    <= rw;
            dev_q   <= devAddr;
            reg_q   <= regAddr;
            num_q   <= numBytes;
            wr_q    <= wrData;
            to_flag <= 1'b0;
            if (rw) rdData <= 32'd0;
         end
         if (load_op) begin
            i2cInstruction <= op_instr;
            i2cByteToSend  <= op_byte;
         end
         if (state == ISSUE) begin
            tcnt <= 12'd0;
         end else if ((state == WAIT_LOW) || (state == WAIT_HIGH)) begin
            tcnt <= tcnt + 12'd1;
         end
         if (to_hit) to_flag <= 1'b1;
         if ((state == WAIT_HIGH) && i2cComplete && (step == ST_READ)) begin
            rdData <= {rdData[23:0], i2cByteReceived};
         end
      end
   end

endmodule
